// File: rtl/shift_pkg.sv
// Shared constants and state encoding for the shifter arbiter and its round-robin helper.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the port not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req[0] && (!req[1] || last_grant)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one external combinational shifter between two requesters, one request at a time,
// holding each result until its owner accepts it.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_arg,
    input  logic [WIDTH-1:0] req0_amt,
    input  logic             req0_type,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_arg,
    input  logic [WIDTH-1:0] req1_amt,
    input  logic             req1_type,
    output logic [WIDTH-1:0] sh_arg,
    output logic [WIDTH-1:0] sh_amount,
    output logic             sh_type,
    input  logic [WIDTH-1:0] sh_result,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             busy
);

    arb_state_t       state;
    logic             last_grant;
    logic             owner;
    logic [WIDTH-1:0] op_arg;
    logic [WIDTH-1:0] op_amt;
    logic             op_type;
    logic [1:0]       gnt;
    logic             grant_en;
    logic             rsp_ack;

    assign grant_en = reset_n && (state == IDLE);

    rr_arb2 u_rr_arb2 (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .enable     (grant_en),
        .gnt        (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Every status and shifter-facing output is forced low while reset is held.
    assign busy       = reset_n && (state != IDLE);
    assign rsp0_valid = reset_n && (state == RESP) && !owner;
    assign rsp1_valid = reset_n && (state == RESP) && owner;
    assign sh_arg     = reset_n ? op_arg  : '0;
    assign sh_amount  = reset_n ? op_amt  : '0;
    assign sh_type    = reset_n ? op_type : 1'b0;

    // A ready from the port that does not own the response is ignored.
    assign rsp_ack = owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_arg     <= '0;
            op_amt     <= '0;
            op_type    <= SHIFT_LOGICAL;
            rsp_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        owner      <= gnt[1];
                        last_grant <= gnt[1];
                        op_arg     <= gnt[1] ? req1_arg  : req0_arg;
                        op_amt     <= gnt[1] ? req1_amt  : req0_amt;
                        op_type    <= gnt[1] ? req1_type : req0_type;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    rsp_result <= sh_result;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter with a behavioural shifter standing in for the datapath one.
module tb_shift_arbiter;
    import shift_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_arg, req1_arg, req0_amt, req1_amt;
    logic        req0_type, req1_type;
    logic [31:0] sh_arg, sh_amount, sh_result;
    logic        sh_type;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic [31:0] arg;
        logic [31:0] amt;
        logic        typ;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs[8];

    shift_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_arg   (req0_arg),
        .req0_amt   (req0_amt),
        .req0_type  (req0_type),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_arg   (req1_arg),
        .req1_amt   (req1_amt),
        .req1_type  (req1_type),
        .sh_arg     (sh_arg),
        .sh_amount  (sh_amount),
        .sh_type    (sh_type),
        .sh_result  (sh_result),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    // Signed amount: positive shifts left, negative shifts right; out-of-range amounts saturate.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] amt, input logic t);
        longint s;
        s = longint'($signed(amt));
        if (s >= 0) begin
            if (s > 31) return 32'h0;
            return a << s;
        end
        s = -s;
        if (s > 31) return t ? {32{a[31]}} : 32'h0;
        return t ? 32'($signed(a) >>> s) : (a >> s);
    endfunction

    assign sh_result = ref_shift(sh_arg, sh_amount, sh_type);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic port, input logic [31:0] arg, input logic [31:0] amt, input logic typ);
        if (port) begin
            req1_valid = 1'b1; req1_arg = arg; req1_amt = amt; req1_type = typ;
        end else begin
            req0_valid = 1'b1; req0_arg = arg; req0_amt = amt; req0_type = typ;
        end
    endtask

    task automatic check_output(input logic port, input logic [31:0] expected, input string name);
        check({name, ".rsp_valid"}, port ? rsp1_valid : rsp0_valid, 1);
        check({name, ".other_rsp_valid"}, port ? rsp0_valid : rsp1_valid, 0);
        check({name, ".rsp_result"}, rsp_result, expected);
    endtask

    // One full transaction from an idle arbiter, with an optional number of stalled response cycles.
    task automatic run_txn(input logic port, input logic [31:0] arg, input logic [31:0] amt,
                           input logic typ, input logic [31:0] expected, input int hold, input string name);
        apply_stimulus(port, arg, amt, typ);
        #1;
        check({name, ".req_ready"}, port ? req1_ready : req0_ready, 1);
        check({name, ".other_req_ready"}, port ? req0_ready : req1_ready, 0);
        step();
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
        #1;
        check({name, ".busy_shift"}, busy, 1);
        check({name, ".sh_arg"}, sh_arg, arg);
        check({name, ".sh_amount"}, sh_amount, amt);
        check({name, ".sh_type"}, sh_type, typ);
        check({name, ".early_rsp"}, port ? rsp1_valid : rsp0_valid, 0);
        step();
        #1;
        check_output(port, expected, name);
        for (int h = 0; h < hold; h++) begin
            step();
            #1;
            check_output(port, expected, {name, ".hold"});
        end
        if (port) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        check({name, ".busy_after"}, busy, 0);
    endtask

    initial begin
        logic        rport;
        logic [31:0] rarg, ramt;
        logic        rtyp;
        logic        exp_port;
        logic [31:0] tie_arg[2];
        logic [31:0] tie_amt[2];
        logic        tie_typ[2];

        vecs[0] = '{1'b0, 32'hF000000F, 32'd3,          SHIFT_LOGICAL, 32'h80000078};
        vecs[1] = '{1'b1, 32'hF000000F, 32'hFFFFFFF5,   SHIFT_ARITH,   32'hFFFE0000};
        vecs[2] = '{1'b1, 32'hF000000F, 32'hFFFFFFF5,   SHIFT_LOGICAL, 32'h001E0000};
        vecs[3] = '{1'b0, 32'h00000001, 32'd31,         SHIFT_LOGICAL, 32'h80000000};
        vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFE1,   SHIFT_ARITH,   32'hFFFFFFFF};
        vecs[5] = '{1'b0, 32'h80000000, 32'hFFFFFFE1,   SHIFT_LOGICAL, 32'h00000001};
        vecs[6] = '{1'b0, 32'h12345678, 32'd0,          SHIFT_LOGICAL, 32'h12345678};
        vecs[7] = '{1'b1, 32'h12345678, 32'd40,         SHIFT_LOGICAL, 32'h00000000};

        reset_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_arg = 32'hAAAA5555; req0_amt = 32'd1; req0_type = 1'b0;
        req1_arg = '0; req1_amt = '0; req1_type = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        step();
        step();
        #1;
        check("reset.req0_ready", req0_ready, 0);
        check("reset.busy", busy, 0);
        check("reset.rsp_result", rsp_result, 0);
        check("reset.sh_arg", sh_arg, 0);
        check("reset.rsp0_valid", rsp0_valid, 0);
        req0_valid = 1'b0;
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].port, vecs[i].arg, vecs[i].amt, vecs[i].typ, vecs[i].expected, 0,
                    $sformatf("vec%0d", i));
        end

        // Tie arbitration straight after reset: grants must alternate starting with port 0.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        tie_arg[0] = 32'h000000FF; tie_amt[0] = 32'd4;        tie_typ[0] = SHIFT_LOGICAL;
        tie_arg[1] = 32'h80000000; tie_amt[1] = 32'hFFFFFFFC; tie_typ[1] = SHIFT_ARITH;
        apply_stimulus(1'b0, tie_arg[0], tie_amt[0], tie_typ[0]);
        apply_stimulus(1'b1, tie_arg[1], tie_amt[1], tie_typ[1]);
        exp_port = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("tie%0d.grant", i), exp_port ? req1_ready : req0_ready, 1);
            check($sformatf("tie%0d.other", i), exp_port ? req0_ready : req1_ready, 0);
            step();
            #1;
            check($sformatf("tie%0d.no_ready_busy", i), {31'd0, req0_ready | req1_ready}, 0);
            step();
            #1;
            check_output(exp_port, ref_shift(tie_arg[exp_port], tie_amt[exp_port], tie_typ[exp_port]),
                         $sformatf("tie%0d", i));
            if (exp_port) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            step();
            rsp0_ready = 1'b0;
            rsp1_ready = 1'b0;
            exp_port = ~exp_port;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure on port 0 while port 1 waits, with a stray rsp1_ready pulse.
        apply_stimulus(1'b0, 32'h0F0F0F0F, 32'd8, SHIFT_LOGICAL);
        #1;
        check("bp.req0_ready", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        apply_stimulus(1'b1, 32'hCAFEBABE, 32'hFFFFFFF0, SHIFT_ARITH);
        #1;
        check("bp.req1_ready_shift", req1_ready, 0);
        step();
        #1;
        for (int c = 0; c < 5; c++) begin
            check_output(1'b0, 32'h0F0F0F00, $sformatf("bp%0d", c));
            check($sformatf("bp%0d.req1_ready", c), req1_ready, 0);
            rsp1_ready = (c == 2);
            step();
            #1;
        end
        rsp1_ready = 1'b0;
        check("stray.rsp0_valid", rsp0_valid, 1);
        check("stray.busy", busy, 1);
        rsp0_ready = 1'b1;
        #1;
        check("bp.req1_ready_before_ack", req1_ready, 0);
        step();
        rsp0_ready = 1'b0;
        #1;
        check("bp.req1_ready_after_ack", req1_ready, 1);
        check("bp.busy_after_ack", busy, 0);
        step();
        req1_valid = 1'b0;
        #1;
        check("bp.sh_arg1", sh_arg, 32'hCAFEBABE);
        step();
        #1;
        check_output(1'b1, 32'hFFFFCAFE, "bp.rsp1");
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;

        // Reset during SHIFT drops the request and restores port 0 tie priority.
        apply_stimulus(1'b0, 32'h00000003, 32'd1, SHIFT_LOGICAL);
        #1;
        check("mid.req0_ready", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid.busy_in_reset", busy, 0);
        check("mid.sh_arg_in_reset", sh_arg, 0);
        check("mid.rsp0_in_reset", rsp0_valid, 0);
        step();
        reset_n = 1'b1;
        #1;
        check("mid.busy", busy, 0);
        check("mid.rsp_result", rsp_result, 0);
        check("mid.rsp0_valid", rsp0_valid, 0);
        check("mid.rsp1_valid", rsp1_valid, 0);
        step();
        #1;
        check("mid.no_late_rsp", rsp0_valid, 0);
        apply_stimulus(1'b0, 32'h1, 32'd1, SHIFT_LOGICAL);
        apply_stimulus(1'b1, 32'h2, 32'd1, SHIFT_LOGICAL);
        #1;
        check("mid.tie_req0", req0_ready, 1);
        check("mid.tie_req1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Random transactions against the behavioural model.
        for (int i = 0; i < 40; i++) begin
            rport = 1'($urandom_range(0, 1));
            rarg  = $urandom;
            rtyp  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       ramt = 32'($urandom_range(0, 31));
                1:       ramt = 32'd0 - 32'($urandom_range(1, 32));
                default: ramt = $urandom;
            endcase
            run_txn(rport, rarg, ramt, rtyp, ref_shift(rarg, ramt, rtyp), int'($urandom_range(0, 2)),
                    $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester scheduler that shares the single combinational Shifter in the Titan datapath between the ALU issue path (port 0) and the load/store alignment path (port 1). It accepts one request at a time under round-robin priority, registers the operands, drives the Shifter for one cycle, captures the result, and holds it in a response register until the owning requester accepts it.

## Interface
- WIDTH, 32, data and shift-amount width; must match Shifter.
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_arg / req1_arg  in  WIDTH  operand.
- req0_amt / req1_amt  in  WIDTH  signed shift amount: positive = left, negative = right.
- req0_type / req1_type  in  1  0 logical, 1 arithmetic.
- sh_arg  out  WIDTH  to Shifter arg.
- sh_amount  out  WIDTH  to Shifter shiftamount.
- sh_type  out  1  to Shifter shifttype.
- sh_result  in  WIDTH  from Shifter result.
- rsp0_valid / rsp1_valid  out  1  result ready for that requester.
- rsp0_ready / rsp1_ready  in  1  requester accepts result.
- rsp_result  out  WIDTH  registered result, shared by both response ports.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SHIFT, RESP.
- IDLE: grant is computed combinationally. Only one valid: grant it. Both valid: grant the port that was not granted last (last_grant).
  - reqN_ready = (state==IDLE) && reset_n && grant==N.
  - On the ready&valid handshake: latch arg, amt, type into the operand registers; owner <= N; last_grant <= N; go to SHIFT.
- SHIFT: sh_arg, sh_amount and sh_type are driven from the operand registers. At end of cycle, capture sh_result into rsp_result; go to RESP.
- RESP: rsp<owner>_valid = 1, the other response valid = 0.
  - When rsp<owner>_ready = 1: go to IDLE.
  - Otherwise hold. rsp_result and the operand registers stay stable.
- The arbiter never transforms operands. Shift semantics belong to Shifter. Amounts outside ±31 pass through unchanged.
- Requests arriving while busy are not accepted: ready stays 0 and the requester must hold valid and its data.
- rspN_ready asserted while rspN_valid = 0 is ignored.

## Timing
- Reset (reset_n = 0 at a clock edge):
  - state <= IDLE, last_grant <= 1 (so port 0 wins the first tie).
  - owner, operand registers, rsp_result <= 0.
  - All valid and ready outputs, busy, and sh_* read 0 while reset_n is low.
- Reset mid-operation: the in-flight request is dropped with no response, and the next cycle is IDLE.
- Latency: request handshake at cycle T, Shifter driven at T+1, rspN_valid high from T+2.
- Response handshake at cycle R: IDLE at R+1. A new request can be accepted at R+1.
- Best-case throughput: one shift per 3 cycles.
- sh_* outputs are registered values. In IDLE and RESP they hold the last operands and have no meaning.
- The request path has no combinational dependency on rsp*_ready. The only combinational paths are valid→ready, through the grant.

## Structure
- Package shift_pkg contains:
  - WIDTH default;
  - SHIFT_LOGICAL = 1'b0 and SHIFT_ARITH = 1'b1;
  - state enum arb_state_t {IDLE, SHIFT, RESP}.
- Sub-module rr_arb2: 2-way round-robin grant.
  - Inputs: req[1:0], last_grant, enable.
  - Outputs: gnt[1:0], one-hot or zero.
- Shifter is instantiated outside the block and connected through the sh_* ports, so the datapath keeps a single shifter instance.

## Test plan
- Single request: port 0 sends arg=32'hF000000F, amt=3, type=0 at cycle T. Required: req0_ready=1 at T, rsp0_valid=1 at T+2, rsp_result=32'h80000078, rsp1_valid=0.
- Right shift: port 1 sends arg=32'hF000000F, amt=32'hFFFFFFF5 (-11), type=1. Required: rsp1_valid with rsp_result=32'hFFFE0000. With type=0, required rsp_result=32'h001E0000.
- Tie after reset: both ports valid in the same cycle. Port 0 is granted first. While both stay valid, grants alternate 0,1,0,1 over four transactions.
- Backpressure: hold rsp0_ready=0 for 5 cycles.
  - rsp0_valid and rsp_result stay stable.
  - req1 stays valid with req1_ready=0 throughout.
  - req1 is accepted on the cycle after rsp0_ready rises.
- Reset mid-operation: deassert reset_n during SHIFT. Required next cycle: busy=0, all valids 0, rsp_result=0, no response delivered. Then port 0 wins a tie.
- Stray ready: pulse rsp1_ready while port 0 owns RESP. Required: no state change, and rsp0_valid stays high.
